rotozoom_param_seq: RTL and testbench

ROTOZOOM_PARAM_SEQ -- requirements
Module: rotozoom_param_seq

---
 rtl/rotozoom_param_seq.sv | 180 ++++++++++++++++++
 tb/tb_rotozoom_param_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rotozoom_param_seq.sv
// +--------------------------------------------------------------------------+
// | rotozoom_param_seq                                                       |
// | Per-frame angle/scale update and texture stride computation for a        |
// | rotozoom raster: trig ROM fetch plus two 16-cycle sequential multiplies. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module rotozoom_param_seq #(
  parameter int                 ZOOM_STEP    = 50,
  parameter logic signed [15:0] SCALE_INIT   = 16'h4000,
  parameter logic signed [15:0] SCALE_MIN    = 16'h0400,
  parameter logic signed [15:0] SCALE_MAX    = 16'h7C00,
  parameter int                 STRIDE_SHIFT = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               inc_angle,
  input  logic               dec_angle,
  input  logic               inc_zoom,
  input  logic               dec_zoom,
  output logic [7:0]         trig_idx,
  output logic               trig_sel,
  input  logic signed [15:0] trig_val,
  output logic [7:0]         angle,
  output logic signed [15:0] scale,
  output logic signed [16:0] u_stride,
  output logic signed [16:0] v_stride,
  output logic               strides_valid,
  output logic               busy,
  output logic               frame_overrun
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_UPDATE    = 3'd1,
    S_FETCH_COS = 3'd2,
    S_MUL_U     = 3'd3,
    S_FETCH_SIN = 3'd4,
    S_MUL_V     = 3'd5,
    S_COMMIT    = 3'd6
  } state_t;

  localparam logic signed [17:0] c_step      = 18'(ZOOM_STEP);
  localparam logic signed [17:0] c_scale_min = {{2{SCALE_MIN[15]}}, SCALE_MIN};
  localparam logic signed [17:0] c_scale_max = {{2{SCALE_MAX[15]}}, SCALE_MAX};

  state_t r_state;
  state_t w_state_next;

  logic [3:0]         r_btn_s1;
  logic [3:0]         r_btn_s2;
  logic               r_vsync;
  logic [3:0]         r_cnt;
  logic signed [31:0] r_mcand;
  logic [15:0]        r_mplier;
  logic signed [31:0] r_acc;
  logic signed [31:0] r_prod_u;

  logic               w_frame_start;
  logic [7:0]         w_angle_next;
  logic signed [17:0] w_scale_sum;
  logic signed [15:0] w_scale_next;
  logic signed [31:0] w_pp;
  logic signed [31:0] w_acc_next;
  logic signed [31:0] w_u_shift;
  logic signed [31:0] w_v_shift;

  // Button bit order in the synchronisers: {inc_angle, dec_angle, inc_zoom, dec_zoom}
  assign w_frame_start = r_vsync & ~vsync;
  assign busy          = (r_state != S_IDLE);
  assign frame_overrun = w_frame_start & busy;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_frame_start) w_state_next = S_UPDATE;
      S_UPDATE:    w_state_next = S_FETCH_COS;
      S_FETCH_COS: if (r_cnt == 4'd1) w_state_next = S_MUL_U;
      S_MUL_U:     if (r_cnt == 4'd15) w_state_next = S_FETCH_SIN;
      S_FETCH_SIN: if (r_cnt == 4'd1) w_state_next = S_MUL_V;
      S_MUL_V:     if (r_cnt == 4'd15) w_state_next = S_COMMIT;
      S_COMMIT:    w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_angle_next = angle;
    w_scale_sum  = {{2{scale[15]}}, scale};
    case (r_btn_s2[3:2])
      2'b10:   w_angle_next = angle + 8'd1;
      2'b01:   w_angle_next = angle - 8'd1;
      default: w_angle_next = angle;
    endcase
    case (r_btn_s2[1:0])
      2'b10:   w_scale_sum = w_scale_sum + c_step;
      2'b01:   w_scale_sum = w_scale_sum - c_step;
      default: w_scale_sum = w_scale_sum;
    endcase
    if (w_scale_sum > c_scale_max)
      w_scale_next = SCALE_MAX;
    else if (w_scale_sum < c_scale_min)
      w_scale_next = SCALE_MIN;
    else
      w_scale_next = w_scale_sum[15:0];
  end

  // Two's-complement multiplier bit 15 carries weight -2^15, so the last step subtracts
  assign w_pp       = r_mplier[0] ? r_mcand : 32'sd0;
  assign w_acc_next = (r_cnt == 4'd15) ? (r_acc - w_pp) : (r_acc + w_pp);
  assign w_u_shift  = r_prod_u >>> STRIDE_SHIFT;
  assign w_v_shift  = w_acc_next >>> STRIDE_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_btn_s1      <= '0;
      r_btn_s2      <= '0;
      r_vsync       <= 1'b1;
      r_cnt         <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_acc         <= '0;
      r_prod_u      <= '0;
      angle         <= '0;
      scale         <= SCALE_INIT;
      u_stride      <= '0;
      v_stride      <= '0;
      strides_valid <= 1'b0;
      trig_idx      <= '0;
      trig_sel      <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_btn_s1      <= {inc_angle, dec_angle, inc_zoom, dec_zoom};
      r_btn_s2      <= r_btn_s1;
      r_vsync       <= vsync;
      r_cnt         <= (w_state_next != r_state) ? 4'd0 : r_cnt + 4'd1;
      strides_valid <= 1'b0;
      case (r_state)
        S_UPDATE: begin
          angle    <= w_angle_next;
          scale    <= w_scale_next;
          trig_idx <= w_angle_next;
          trig_sel <= 1'b0;
        end
        S_FETCH_COS, S_FETCH_SIN: begin
          if (r_cnt == 4'd1) begin
            r_mcand  <= {{16{scale[15]}}, scale};
            r_mplier <= trig_val;
            r_acc    <= '0;
          end
        end
        S_MUL_U, S_MUL_V: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand <<< 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == 4'd15) begin
            if (r_state == S_MUL_U) begin
              r_prod_u <= w_acc_next;
              trig_idx <= angle;
              trig_sel <= 1'b1;
            end else begin
              // Both strides land on the edge entering COMMIT, alongside the valid pulse
              u_stride      <= w_u_shift[16:0];
              v_stride      <= w_v_shift[16:0];
              strides_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rotozoom_param_seq.sv
// Directed bench for rotozoom_param_seq: timing of the frame sequence, stride
// arithmetic, angle wrap, scale saturation, overrun and mid-frame reset.
`timescale 1ns/1ps
`default_nettype none

module tb_rotozoom_param_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vsync;
  logic               inc_angle, dec_angle, inc_zoom, dec_zoom;
  logic [7:0]         trig_idx;
  logic               trig_sel;
  logic signed [15:0] trig_val;
  logic [7:0]         angle;
  logic signed [15:0] scale;
  logic signed [16:0] u_stride, v_stride;
  logic               strides_valid, busy, frame_overrun;

  logic signed [15:0] rom_cos, rom_sin;
  int n_assert = 0;
  int n_fail   = 0;
  int seen;

  rotozoom_param_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vsync         (vsync),
    .inc_angle     (inc_angle),
    .dec_angle     (dec_angle),
    .inc_zoom      (inc_zoom),
    .dec_zoom      (dec_zoom),
    .trig_idx      (trig_idx),
    .trig_sel      (trig_sel),
    .trig_val      (trig_val),
    .angle         (angle),
    .scale         (scale),
    .u_stride      (u_stride),
    .v_stride      (v_stride),
    .strides_valid (strides_valid),
    .busy          (busy),
    .frame_overrun (frame_overrun)
  );

  always #5 clk = ~clk;

  // ROM answers one cycle after the request; the angle index is ignored here
  always @(posedge clk) trig_val <= trig_sel ? rom_sin : rom_cos;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input logic ia, input logic da, input logic iz, input logic dz);
    @(negedge clk);
    inc_angle = ia; dec_angle = da; inc_zoom = iz; dec_zoom = dz;
    tick(3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic do_frame();
    int k;
    k = 0;
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    while (!strides_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) check("frame_timeout", 32'(strides_valid), 32'd1);
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b1;
    inc_angle = 0; dec_angle = 0; inc_zoom = 0; dec_zoom = 0;
    rom_cos = 16'sd32767; rom_sin = 16'sd0;
    tick(3);
    check("rst_angle",    32'(angle),         32'h0);
    check("rst_scale",    32'(scale[15:0]),   32'h4000);
    check("rst_u",        32'(u_stride[16:0]), 32'h0);
    check("rst_v",        32'(v_stride[16:0]), 32'h0);
    check("rst_valid",    32'(strides_valid), 32'h0);
    check("rst_busy",     32'(busy),          32'h0);
    check("rst_trig_idx", 32'(trig_idx),      32'h0);
    check("rst_trig_sel", 32'(trig_sel),      32'h0);
    check("rst_overrun",  32'(frame_overrun), 32'h0);
    rst_n = 1'b1;
    tick(3);

    // Exact sequence timing from frame start N
    @(negedge clk) vsync = 1'b0; #1;
    check("n0_busy", 32'(busy), 32'h0);
    @(negedge clk) vsync = 1'b1;
    check("n1_busy", 32'(busy), 32'h1);
    tick(1);
    check("n2_trig_idx", 32'(trig_idx), 32'h0);
    check("n2_trig_sel", 32'(trig_sel), 32'h0);
    tick(18);
    check("n20_trig_sel", 32'(trig_sel), 32'h1);
    tick(17);
    check("n37_valid", 32'(strides_valid), 32'h0);
    tick(1);
    check("n38_valid", 32'(strides_valid), 32'h1);
    check("n38_u",     32'(u_stride[16:0]), 32'd1023);
    check("n38_v",     32'(v_stride[16:0]), 32'h0);
    check("n38_angle", 32'(angle), 32'h0);
    tick(1);
    check("n39_valid", 32'(strides_valid), 32'h0);
    check("n39_busy",  32'(busy), 32'h0);

    // Overrun: second falling edge at N+10
    tick(2);
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    tick(8);
    @(negedge clk) vsync = 1'b0; #1;
    check("ovr_pulse", 32'(frame_overrun), 32'h1);
    @(negedge clk); #1;
    check("ovr_one_cycle", 32'(frame_overrun), 32'h0);
    vsync = 1'b1;
    tick(26);
    check("ovr_n37_valid", 32'(strides_valid), 32'h0);
    tick(1);
    check("ovr_n38_valid", 32'(strides_valid), 32'h1);
    check("ovr_n38_u",     32'(u_stride[16:0]), 32'd1023);
    check("ovr_n38_v",     32'(v_stride[16:0]), 32'h0);
    seen = 0;
    repeat (60) begin @(negedge clk); if (strides_valid) seen++; end
    check("ovr_no_second", 32'(seen), 32'h0);

    // Reset at N+20 aborts the frame
    set_btn(1, 0, 0, 0);
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
    tick(18);
    check("mid_busy",  32'(busy),  32'h1);
    check("mid_angle", 32'(angle), 32'h1);
    tick(1);
    rst_n = 1'b0; #1;
    check("abort_busy",  32'(busy), 32'h0);
    check("abort_angle", 32'(angle), 32'h0);
    check("abort_u",     32'(u_stride[16:0]), 32'h0);
    check("abort_sel",   32'(trig_sel), 32'h0);
    check("abort_scale", 32'(scale[15:0]), 32'h4000);
    inc_angle = 1'b0;
    tick(2);
    rst_n = 1'b1;
    seen = 0;
    repeat (60) begin @(negedge clk); if (strides_valid) seen++; end
    check("abort_no_valid", 32'(seen), 32'h0);
    do_frame();
    check("post_rst_u", 32'(u_stride[16:0]), 32'd1023);

    // Angle wrap and both-buttons hold
    set_btn(0, 1, 0, 0); do_frame();
    check("wrap_dec", 32'(angle), 32'd255);
    set_btn(1, 1, 0, 0); do_frame();
    check("both_hold", 32'(angle), 32'd255);
    set_btn(1, 0, 0, 0); do_frame();
    check("wrap_inc", 32'(angle), 32'd0);

    // Angle 127 -> 128 with negative cosine
    repeat (126) do_frame();
    do_frame();
    check("angle_127", 32'(angle), 32'd127);
    rom_cos = -16'sd32767;
    do_frame();
    check("angle_128", 32'(angle), 32'd128);
    check("neg_u", 32'(u_stride[16:0]), 32'h1FC00);
    check("neg_v", 32'(v_stride[16:0]), 32'h0);

    // Non-zero sine, both signs
    set_btn(0, 0, 0, 0);
    rom_cos = 16'sd32767; rom_sin = 16'sd16384;
    do_frame();
    check("sin_pos_v", 32'(v_stride[16:0]), 32'h00200);
    check("sin_pos_u", 32'(u_stride[16:0]), 32'd1023);
    rom_sin = -16'sd16384;
    do_frame();
    check("sin_neg_v", 32'(v_stride[16:0]), 32'h1FE00);

    // Scale saturation upward
    do_reset();
    set_btn(0, 0, 1, 0);
    do_frame();
    check("zoom_one", 32'(scale[15:0]), 32'h4032);
    repeat (306) do_frame();
    check("zoom_307", 32'(scale[15:0]), 32'h7BF6);
    do_frame();
    check("zoom_max", 32'(scale[15:0]), 32'h7C00);
    repeat (92) do_frame();
    check("zoom_hold_max", 32'(scale[15:0]), 32'h7C00);
    check("max_u", 32'(u_stride[16:0]), 32'h007BF);
    check("max_v", 32'(v_stride[16:0]), 32'h1FC20);

    // Scale saturation downward
    do_reset();
    set_btn(0, 0, 0, 1);
    repeat (307) do_frame();
    check("unzoom_307", 32'(scale[15:0]), 32'h040A);
    do_frame();
    check("unzoom_min", 32'(scale[15:0]), 32'h0400);
    repeat (92) do_frame();
    check("unzoom_hold_min", 32'(scale[15:0]), 32'h0400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
